// File: rtl/rps_match_ctrl_if.sv
// Bus between the rock-paper-scissors validIO stage / round driver and the
// match controller: move and strobe inputs, judged-round and match status outputs.
interface rps_match_ctrl_if #(
   parameter int SCORE_W = 4,
   parameter int RND_W   = 4
);
   logic               start;
   logic               play;
   logic [2:0]         inA;
   logic [2:0]         inB;
   logic               valid;
   logic               round_done;
   logic [1:0]         round_result;
   logic [SCORE_W-1:0] scoreA;
   logic [SCORE_W-1:0] scoreB;
   logic [RND_W-1:0]   round_cnt;
   logic               busy;
   logic               match_over;
   logic [1:0]         match_winner;

   modport master (
      output start, play, inA, inB, valid,
      input  round_done, round_result, scoreA, scoreB, round_cnt,
             busy, match_over, match_winner
   );

   modport slave (
      input  start, play, inA, inB, valid,
      output round_done, round_result, scoreA, scoreB, round_cnt,
             busy, match_over, match_winner
   );
endinterface

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller: captures a round on play, judges it
// one cycle later, keeps per-player scores and declares the match winner.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   S_IDLE      | after reset, waiting for start; play ignored
//   S_WAIT_PLAY | match running, waiting for play to capture a round
//   S_JUDGE     | one cycle judging the latched moves (busy=1)
//   S_DONE      | match decided, outputs frozen until start or reset
module rps_match_ctrl #(
   parameter int WIN_TARGET = 3,
   parameter int MAX_ROUNDS = 9,
   parameter int SCORE_W    = 4,
   parameter int RND_W      = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   rps_match_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_PLAY = 2'd1,
      S_JUDGE     = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   localparam logic [1:0] RES_DRAW    = 2'b00;
   localparam logic [1:0] RES_A       = 2'b01;
   localparam logic [1:0] RES_B       = 2'b10;
   localparam logic [1:0] RES_INVALID = 2'b11;

   localparam logic [2:0] MV_SCISSORS = 3'b001;
   localparam logic [2:0] MV_ROCK     = 3'b010;
   localparam logic [2:0] MV_PAPER    = 3'b100;

   localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);
   localparam logic [RND_W-1:0]   MAX_R = RND_W'(MAX_ROUNDS);

   state_t             state_q, state_d;
   logic [2:0]         mv_a_q, mv_a_d;
   logic [2:0]         mv_b_q, mv_b_d;
   logic               vld_q, vld_d;
   logic [SCORE_W-1:0] score_a_q, score_a_d;
   logic [SCORE_W-1:0] score_b_q, score_b_d;
   logic [RND_W-1:0]   rnd_q, rnd_d;
   logic [1:0]         result_q, result_d;
   logic               round_done_q, round_done_d;
   logic               over_q, over_d;
   logic [1:0]         winner_q, winner_d;
   logic               a_beats_b;

   // A wins when its move beats B's under the scissors<rock<paper<scissors cycle.
   assign a_beats_b = ((mv_a_q == MV_SCISSORS) && (mv_b_q == MV_PAPER))    ||
                      ((mv_a_q == MV_ROCK)     && (mv_b_q == MV_SCISSORS)) ||
                      ((mv_a_q == MV_PAPER)    && (mv_b_q == MV_ROCK));

   // Next-state and register-update logic; start overrides everything else.
   always_comb begin
      state_d      = state_q;
      mv_a_d       = mv_a_q;
      mv_b_d       = mv_b_q;
      vld_d        = vld_q;
      score_a_d    = score_a_q;
      score_b_d    = score_b_q;
      rnd_d        = rnd_q;
      result_d     = result_q;
      round_done_d = 1'b0;
      over_d       = over_q;
      winner_d     = winner_q;

      if (bus.start) begin
         score_a_d = '0;
         score_b_d = '0;
         rnd_d     = '0;
         result_d  = RES_DRAW;
         winner_d  = 2'b00;
         over_d    = 1'b0;
         state_d   = S_WAIT_PLAY;
      end else begin
         case (state_q)
            S_WAIT_PLAY: begin
               if (bus.play) begin
                  mv_a_d  = bus.inA;
                  mv_b_d  = bus.inB;
                  vld_d   = bus.valid;
                  state_d = S_JUDGE;
               end
            end
            S_JUDGE: begin
               round_done_d = 1'b1;
               if (!vld_q) begin
                  result_d = RES_INVALID;
                  state_d  = S_WAIT_PLAY;
               end else begin
                  if (mv_a_q == mv_b_q) begin
                     result_d = RES_DRAW;
                  end else if (a_beats_b) begin
                     result_d  = RES_A;
                     score_a_d = score_a_q + SCORE_W'(1);
                  end else begin
                     result_d  = RES_B;
                     score_b_d = score_b_q + SCORE_W'(1);
                  end
                  rnd_d = rnd_q + RND_W'(1);

                  // Match end is judged on the scores including this round.
                  if (score_a_d == WIN_T) begin
                     winner_d = RES_A;
                     over_d   = 1'b1;
                     state_d  = S_DONE;
                  end else if (score_b_d == WIN_T) begin
                     winner_d = RES_B;
                     over_d   = 1'b1;
                     state_d  = S_DONE;
                  end else if (rnd_d == MAX_R) begin
                     if (score_a_d > score_b_d) begin
                        winner_d = RES_A;
                     end else if (score_b_d > score_a_d) begin
                        winner_d = RES_B;
                     end else begin
                        winner_d = 2'b00;
                     end
                     over_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_WAIT_PLAY;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         mv_a_q       <= '0;
         mv_b_q       <= '0;
         vld_q        <= 1'b0;
         score_a_q    <= '0;
         score_b_q    <= '0;
         rnd_q        <= '0;
         result_q     <= 2'b00;
         round_done_q <= 1'b0;
         over_q       <= 1'b0;
         winner_q     <= 2'b00;
      end else begin
         state_q      <= state_d;
         mv_a_q       <= mv_a_d;
         mv_b_q       <= mv_b_d;
         vld_q        <= vld_d;
         score_a_q    <= score_a_d;
         score_b_q    <= score_b_d;
         rnd_q        <= rnd_d;
         result_q     <= result_d;
         round_done_q <= round_done_d;
         over_q       <= over_d;
         winner_q     <= winner_d;
      end
   end

   assign bus.round_done   = round_done_q;
   assign bus.round_result = result_q;
   assign bus.scoreA       = score_a_q;
   assign bus.scoreB       = score_b_q;
   assign bus.round_cnt    = rnd_q;
   assign bus.busy         = (state_q == S_JUDGE);
   assign bus.match_over   = over_q;
   assign bus.match_winner = winner_q;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Bench for rps_match_ctrl: two instances (WIN_TARGET 3 and 4) share the same
// stimulus; a reference model queues the expected outcome of each round.
module tb_rps_match_ctrl;

   localparam logic [2:0] SC = 3'b001;
   localparam logic [2:0] RK = 3'b010;
   localparam logic [2:0] PA = 3'b100;
   localparam int MAXR = 9;

   typedef struct {
      int res;
      int sa;
      int sb;
      int rn;
      int over;
      int win;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start_s;
   logic       play_s;
   logic [2:0] inA_s;
   logic [2:0] inB_s;
   logic       valid_s;

   int n_checks = 0;
   int n_errors = 0;

   exp_t q0[$];
   exp_t q1[$];
   int   m_sa[2];
   int   m_sb[2];
   int   m_rn[2];
   bit   m_act[2];
   int   tgt[2];

   rps_match_ctrl_if #(.SCORE_W(4), .RND_W(4)) if0 ();
   rps_match_ctrl_if #(.SCORE_W(4), .RND_W(4)) if1 ();

   assign if0.start = start_s;
   assign if0.play  = play_s;
   assign if0.inA   = inA_s;
   assign if0.inB   = inB_s;
   assign if0.valid = valid_s;
   assign if1.start = start_s;
   assign if1.play  = play_s;
   assign if1.inA   = inA_s;
   assign if1.inB   = inB_s;
   assign if1.valid = valid_s;

   rps_match_ctrl #(.WIN_TARGET(3), .MAX_ROUNDS(9), .SCORE_W(4), .RND_W(4)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   rps_match_ctrl #(.WIN_TARGET(4), .MAX_ROUNDS(9), .SCORE_W(4), .RND_W(4)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_start();
      for (int d = 0; d < 2; d++) begin
         m_sa[d]  = 0;
         m_sb[d]  = 0;
         m_rn[d]  = 0;
         m_act[d] = 1'b1;
      end
   endtask

   task automatic model_play(input int d, input logic [2:0] a, input logic [2:0] b, input logic v);
      exp_t e;
      int   r;
      if (!m_act[d]) return;
      e.over = 0;
      e.win  = 0;
      if (!v) begin
         r = 3;
      end else begin
         if (a == b) r = 0;
         else if ((a == SC && b == PA) || (a == RK && b == SC) || (a == PA && b == RK)) r = 1;
         else r = 2;
         if (r == 1) m_sa[d]++;
         if (r == 2) m_sb[d]++;
         m_rn[d]++;
         if (m_sa[d] == tgt[d]) begin
            e.over = 1; e.win = 1;
         end else if (m_sb[d] == tgt[d]) begin
            e.over = 1; e.win = 2;
         end else if (m_rn[d] == MAXR) begin
            e.over = 1;
            e.win  = (m_sa[d] > m_sb[d]) ? 1 : ((m_sb[d] > m_sa[d]) ? 2 : 0);
         end
      end
      e.res = r;
      e.sa  = m_sa[d];
      e.sb  = m_sb[d];
      e.rn  = m_rn[d];
      if (e.over != 0) m_act[d] = 1'b0;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // Entered and left on a negedge.
   task automatic do_start();
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      model_start();
   endtask

   task automatic do_play(input logic [2:0] a, input logic [2:0] b, input logic v);
      bit e0, e1;
      e0 = m_act[0];
      e1 = m_act[1];
      model_play(0, a, b, v);
      model_play(1, a, b, v);
      inA_s = a; inB_s = b; valid_s = v; play_s = 1'b1;
      @(negedge clk);
      play_s = 1'b0;
      inA_s = 3'b111; inB_s = 3'b000; valid_s = 1'b1;
      check("d0_busy_judge", if0.busy, e0);
      check("d1_busy_judge", if1.busy, e1);
      check("d0_rd_early", if0.round_done, 0);
      @(negedge clk);
      check("d0_rd_timing", if0.round_done, e0);
      check("d1_rd_timing", if1.round_done, e1);
   endtask

   // Scoreboard: every round_done pulse must match the next queued expectation.
   always @(negedge clk) begin : mon0
      exp_t e;
      if (if0.round_done === 1'b1) begin
         if (q0.size() == 0) check("d0_spurious_round_done", 1, 0);
         else begin
            e = q0.pop_front();
            check("d0_result", if0.round_result, e.res);
            check("d0_scoreA", if0.scoreA, e.sa);
            check("d0_scoreB", if0.scoreB, e.sb);
            check("d0_round_cnt", if0.round_cnt, e.rn);
            check("d0_match_over", if0.match_over, e.over);
            check("d0_winner", if0.match_winner, e.win);
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (if1.round_done === 1'b1) begin
         if (q1.size() == 0) check("d1_spurious_round_done", 1, 0);
         else begin
            e = q1.pop_front();
            check("d1_result", if1.round_result, e.res);
            check("d1_scoreA", if1.scoreA, e.sa);
            check("d1_scoreB", if1.scoreB, e.sb);
            check("d1_round_cnt", if1.round_cnt, e.rn);
            check("d1_match_over", if1.match_over, e.over);
            check("d1_winner", if1.match_winner, e.win);
         end
      end
   end

   initial begin
      logic [2:0] nine_a [9];
      logic [2:0] nine_b [9];
      tgt[0] = 3;
      tgt[1] = 4;
      for (int d = 0; d < 2; d++) begin
         m_sa[d] = 0; m_sb[d] = 0; m_rn[d] = 0; m_act[d] = 1'b0;
      end
      rst_n = 1'b1; start_s = 1'b0; play_s = 1'b0;
      inA_s = 3'b000; inB_s = 3'b000; valid_s = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_round_done", if0.round_done, 0);
      check("rst_result", if0.round_result, 0);
      check("rst_scoreA", if0.scoreA, 0);
      check("rst_scoreB", if0.scoreB, 0);
      check("rst_round_cnt", if0.round_cnt, 0);
      check("rst_busy", if0.busy, 0);
      check("rst_match_over", if0.match_over, 0);
      check("rst_winner", if0.match_winner, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // play in IDLE is ignored
      do_play(RK, SC, 1'b1);

      // first match: A win, invalid round, then A reaches target on dut0
      do_start();
      do_play(RK, SC, 1'b1);
      do_play(3'b101, SC, 1'b0);
      do_play(SC, PA, 1'b1);
      do_play(PA, RK, 1'b1);
      check("d0_over_level", if0.match_over, 1);
      check("d0_winner_level", if0.match_winner, 1);
      do_play(RK, SC, 1'b1);
      check("d0_done_hold_scoreA", if0.scoreA, 3);
      check("d0_done_hold_over", if0.match_over, 1);

      // nine rounds: 2 A, 2 B, 5 draws -> tie on both
      nine_a = '{RK, SC, PA, SC, PA, RK, SC, RK, PA};
      nine_b = '{SC, RK, PA, PA, SC, RK, SC, RK, PA};
      do_start();
      for (int i = 0; i < 9; i++) do_play(nine_a[i], nine_b[i], 1'b1);
      check("d0_tie_over", if0.match_over, 1);
      check("d1_tie_winner", if1.match_winner, 0);

      // 3-2 finish in round nine
      nine_a = '{RK, SC, SC, PA, RK, SC, PA, RK, PA};
      nine_b = '{SC, RK, PA, SC, RK, SC, PA, RK, RK};
      do_start();
      for (int i = 0; i < 9; i++) do_play(nine_a[i], nine_b[i], 1'b1);
      check("d1_32_round_cnt", if1.round_cnt, 9);
      check("d1_32_winner", if1.match_winner, 1);

      // start and play together with scoreA=2: play dropped
      do_start();
      do_play(RK, SC, 1'b1);
      do_play(PA, RK, 1'b1);
      check("d0_pre_scoreA", if0.scoreA, 2);
      start_s = 1'b1; play_s = 1'b1; inA_s = RK; inB_s = SC; valid_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0; play_s = 1'b0;
      model_start();
      check("d0_sp_scoreA", if0.scoreA, 0);
      check("d1_sp_scoreA", if1.scoreA, 0);
      check("d0_sp_busy", if0.busy, 0);
      @(negedge clk);
      check("d0_sp_round_done", if0.round_done, 0);
      do_play(RK, SC, 1'b1);

      // reset while in JUDGE
      inA_s = RK; inB_s = SC; valid_s = 1'b1; play_s = 1'b1;
      @(posedge clk);
      #2;
      play_s = 1'b0;
      check("d0_rj_busy", if0.busy, 1);
      rst_n = 1'b0;
      #1;
      check("d0_rj_scoreA", if0.scoreA, 0);
      check("d0_rj_busy_clr", if0.busy, 0);
      check("d0_rj_round_cnt", if0.round_cnt, 0);
      check("d1_rj_scoreA", if1.scoreA, 0);
      check("d0_rj_result", if0.round_result, 0);
      m_act[0] = 1'b0;
      m_act[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("d0_rj_idle_busy", if0.busy, 0);
      do_start();
      do_play(RK, SC, 1'b1);
      do_play(SC, RK, 1'b1);

      repeat (2) @(negedge clk);
      check("d0_queue_drained", q0.size(), 0);
      check("d1_queue_drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
